// File: rtl/mips_pkg.sv
// Shared MIPS pipeline encodings: ALUOp values, R-type funct codes, control-bit
// positions and the ID/EX bubble constants.
package mips_pkg;

    localparam logic [2:0] AluOpMem    = 3'b000;
    localparam logic [2:0] AluOpBranch = 3'b001;
    localparam logic [2:0] AluOpRtype  = 3'b010;
    localparam logic [2:0] AluOpAndi   = 3'b011;
    localparam logic [2:0] AluOpOri    = 3'b100;
    localparam logic [2:0] AluOpSlti   = 3'b111;

    localparam logic [5:0] FunctAdd = 6'b100000;
    localparam logic [5:0] FunctSub = 6'b100010;
    localparam logic [5:0] FunctAnd = 6'b100100;
    localparam logic [5:0] FunctOr  = 6'b100101;
    localparam logic [5:0] FunctSlt = 6'b101010;

    // Bit positions inside the 7-bit control bundle, reg_dst is the MSB
    localparam int unsigned CtrlRegDst   = 6;
    localparam int unsigned CtrlAluSrc   = 5;
    localparam int unsigned CtrlMemRead  = 4;
    localparam int unsigned CtrlMemWrite = 3;
    localparam int unsigned CtrlMemToReg = 2;
    localparam int unsigned CtrlRegWrite = 1;
    localparam int unsigned CtrlBranch   = 0;

    localparam logic [6:0] CtrlBubble  = 7'b0000000;
    localparam logic [2:0] AluOpBubble = AluOpMem;
    localparam logic [5:0] FunctBubble = 6'b000000;

endpackage

// File: rtl/hazard_unit.sv
// Load-use hazard detection and front-end write enables, purely combinational.
module hazard_unit (
    input  logic       ex_valid,
    input  logic       ex_mem_read,
    input  logic [4:0] ex_rt,
    input  logic       id_valid,
    input  logic [4:0] id_rs,
    input  logic [4:0] id_rt,
    input  logic       flush,
    input  logic       hold,
    output logic       lu,
    output logic       pc_write,
    output logic       if_id_write
);

    always_comb begin
        lu = ex_valid & ex_mem_read & id_valid & (ex_rt != 5'd0)
             & ((ex_rt == id_rs) | (ex_rt == id_rt));
        // A flush lets the fetch redirect advance even while a load-use is seen
        pc_write    = ~hold & (flush | ~lu);
        if_id_write = ~hold & (flush | ~lu);
    end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use bubble insertion, flush, hold and a
// saturating count of inserted load-use bubbles.
module id_ex_stage #(
    parameter int unsigned DW = 32,
    parameter int unsigned CW = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          id_valid,
    input  logic [DW-1:0] id_pc4,
    input  logic [DW-1:0] id_rs_data,
    input  logic [DW-1:0] id_rt_data,
    input  logic [DW-1:0] id_imm,
    input  logic [4:0]    id_rs,
    input  logic [4:0]    id_rt,
    input  logic [4:0]    id_rd,
    input  logic [5:0]    id_funct,
    input  logic [2:0]    id_alu_op,
    input  logic [6:0]    id_ctrl,
    input  logic          flush,
    input  logic          hold,
    output logic          ex_valid,
    output logic [DW-1:0] ex_pc4,
    output logic [DW-1:0] ex_rs_data,
    output logic [DW-1:0] ex_rt_data,
    output logic [DW-1:0] ex_imm,
    output logic [4:0]    ex_rs,
    output logic [4:0]    ex_rt,
    output logic [4:0]    ex_rd,
    output logic [5:0]    ex_funct,
    output logic [2:0]    ex_alu_op,
    output logic [6:0]    ex_ctrl,
    output logic          pc_write,
    output logic          if_id_write,
    output logic [CW-1:0] stall_cnt
);
    import mips_pkg::*;

    logic lu;

    hazard_unit u_hazard (
        .ex_valid    (ex_valid),
        .ex_mem_read (ex_ctrl[CtrlMemRead]),
        .ex_rt       (ex_rt),
        .id_valid    (id_valid),
        .id_rs       (id_rs),
        .id_rt       (id_rt),
        .flush       (flush),
        .hold        (hold),
        .lu          (lu),
        .pc_write    (pc_write),
        .if_id_write (if_id_write)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_valid   <= 1'b0;
            ex_pc4     <= '0;
            ex_rs_data <= '0;
            ex_rt_data <= '0;
            ex_imm     <= '0;
            ex_rs      <= '0;
            ex_rt      <= '0;
            ex_rd      <= '0;
            ex_funct   <= FunctBubble;
            ex_alu_op  <= AluOpBubble;
            ex_ctrl    <= CtrlBubble;
        end else if (!hold) begin
            if (flush || lu) begin
                ex_valid   <= 1'b0;
                ex_pc4     <= '0;
                ex_rs_data <= '0;
                ex_rt_data <= '0;
                ex_imm     <= '0;
                ex_rs      <= '0;
                ex_rt      <= '0;
                ex_rd      <= '0;
                ex_funct   <= FunctBubble;
                ex_alu_op  <= AluOpBubble;
                ex_ctrl    <= CtrlBubble;
            end else begin
                ex_valid   <= id_valid;
                ex_pc4     <= id_pc4;
                ex_rs_data <= id_rs_data;
                ex_rt_data <= id_rt_data;
                ex_imm     <= id_imm;
                ex_rs      <= id_rs;
                ex_rt      <= id_rt;
                ex_rd      <= id_rd;
                ex_funct   <= id_funct;
                ex_alu_op  <= id_alu_op;
                ex_ctrl    <= id_ctrl;
            end
        end
    end

    // Only bubbles caused by load-use count; flush and hold take precedence
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt <= '0;
        end else if (!hold && !flush && lu && (stall_cnt != {CW{1'b1}})) begin
            stall_cnt <= stall_cnt + CW'(1);
        end
    end

endmodule

// File: tb/tb_id_ex_stage.sv
// Scoreboard bench for id_ex_stage: a driver predicts each cycle from a
// behavioural model and a monitor compares the DUT against the queued results.
module tb_id_ex_stage;

    localparam int DW = 32;
    localparam int CW = 2;
    localparam int CntMax = (1 << CW) - 1;

    typedef struct packed {
        logic        valid;
        logic [31:0] pc4;
        logic [31:0] rs_data;
        logic [31:0] rt_data;
        logic [31:0] imm;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  rd;
        logic [5:0]  funct;
        logic [2:0]  alu_op;
        logic [6:0]  ctrl;
    } stage_t;

    typedef struct packed {
        stage_t        st;
        logic [CW-1:0] cnt;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    stage_t id_in = '0;
    logic flush = 1'b0;
    logic hold = 1'b0;

    logic          ex_valid;
    logic [DW-1:0] ex_pc4, ex_rs_data, ex_rt_data, ex_imm;
    logic [4:0]    ex_rs, ex_rt, ex_rd;
    logic [5:0]    ex_funct;
    logic [2:0]    ex_alu_op;
    logic [6:0]    ex_ctrl;
    logic          pc_write, if_id_write;
    logic [CW-1:0] stall_cnt;
    stage_t        act;

    assign act = {ex_valid, ex_pc4, ex_rs_data, ex_rt_data, ex_imm, ex_rs, ex_rt, ex_rd,
                  ex_funct, ex_alu_op, ex_ctrl};

    always #5 clk = ~clk;

    id_ex_stage #(.DW(DW), .CW(CW)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .id_valid    (id_in.valid),
        .id_pc4      (id_in.pc4),
        .id_rs_data  (id_in.rs_data),
        .id_rt_data  (id_in.rt_data),
        .id_imm      (id_in.imm),
        .id_rs       (id_in.rs),
        .id_rt       (id_in.rt),
        .id_rd       (id_in.rd),
        .id_funct    (id_in.funct),
        .id_alu_op   (id_in.alu_op),
        .id_ctrl     (id_in.ctrl),
        .flush       (flush),
        .hold        (hold),
        .ex_valid    (ex_valid),
        .ex_pc4      (ex_pc4),
        .ex_rs_data  (ex_rs_data),
        .ex_rt_data  (ex_rt_data),
        .ex_imm      (ex_imm),
        .ex_rs       (ex_rs),
        .ex_rt       (ex_rt),
        .ex_rd       (ex_rd),
        .ex_funct    (ex_funct),
        .ex_alu_op   (ex_alu_op),
        .ex_ctrl     (ex_ctrl),
        .pc_write    (pc_write),
        .if_id_write (if_id_write),
        .stall_cnt   (stall_cnt)
    );

    int checks = 0;
    int errors = 0;

    logic [1:0] comb_q[$];
    exp_t       st_q[$];

    // Reference state: what EX should hold and how many load-use bubbles so far
    stage_t m_ex = '0;
    int     m_cnt = 0;

    localparam logic [6:0] CtrlLw  = 7'b0110110;
    localparam logic [6:0] CtrlR   = 7'b1000010;
    localparam logic [6:0] CtrlOri = 7'b0100010;

    task automatic check(input string name, input logic [191:0] got, input logic [191:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    function automatic stage_t mk(input logic [4:0] rs, input logic [4:0] rt,
                                  input logic [4:0] rd, input logic [5:0] funct,
                                  input logic [2:0] alu_op, input logic [6:0] ctrl,
                                  input logic [31:0] imm);
        stage_t s;
        s.valid   = 1'b1;
        s.pc4     = $urandom & 32'hffff_fffc;
        s.rs_data = $urandom;
        s.rt_data = $urandom;
        s.imm     = imm;
        s.rs      = rs;
        s.rt      = rt;
        s.rd      = rd;
        s.funct   = funct;
        s.alu_op  = alu_op;
        s.ctrl    = ctrl;
        return s;
    endfunction

    function automatic logic [4:0] pick_reg();
        case ($urandom_range(0, 3))
            0: return 5'd0;
            1: return 5'd8;
            2: return 5'd9;
            default: return 5'($urandom);
        endcase
    endfunction

    function automatic stage_t rand_in();
        stage_t s;
        s = mk(pick_reg(), pick_reg(), 5'($urandom), 6'($urandom), 3'($urandom),
               7'($urandom), $urandom);
        s.valid = ($urandom_range(0, 7) != 0);
        return s;
    endfunction

    // One clock cycle: drive at the falling edge, predict, optionally reset mid-cycle
    task automatic cycle(input stage_t in, input logic fl, input logic hd, input bit rst_mid);
        bit lu;
        bit adv;
        @(negedge clk);
        rst_n = 1'b1;
        id_in = in;
        flush = fl;
        hold  = hd;
        #1;
        lu = m_ex.valid && m_ex.ctrl[4] && in.valid && (m_ex.rt != 5'd0) &&
             ((m_ex.rt == in.rs) || (m_ex.rt == in.rt));
        adv = !hd && (fl || !lu);
        comb_q.push_back({adv, adv});
        if (!hd) begin
            if (fl || lu) m_ex = '0;
            else m_ex = in;
            if (!fl && lu && m_cnt < CntMax) m_cnt++;
        end
        if (rst_mid) begin
            #2;
            rst_n = 1'b0;
            #1;
            check("async_rst_valid", 192'(ex_valid), 192'(0));
            check("async_rst_ctrl", 192'(ex_ctrl), 192'(0));
            check("async_rst_cnt", 192'(stall_cnt), 192'(0));
            m_ex  = '0;
            m_cnt = 0;
        end
        st_q.push_back({m_ex, CW'(m_cnt)});
    endtask

    initial begin : monitor
        logic [1:0] ce;
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (comb_q.size() != 0) begin
                ce = comb_q.pop_front();
                check("pc_write", 192'(pc_write), 192'(ce[1]));
                check("if_id_write", 192'(if_id_write), 192'(ce[0]));
            end
            @(posedge clk);
            #1;
            if (st_q.size() != 0) begin
                e = st_q.pop_front();
                check("ex_fields", 192'(act), 192'(e.st));
                check("stall_cnt", 192'(stall_cnt), 192'(e.cnt));
            end
        end
    end

    initial begin : driver
        stage_t lw, add, ori;
        #3;
        check("reset_fields", 192'(act), 192'(0));
        check("reset_cnt", 192'(stall_cnt), 192'(0));

        // Load followed by dependent add: one bubble, then the add enters EX
        lw  = mk(5'd0, 5'd8, 5'd0, 6'd0, 3'b000, CtrlLw, 32'h10);
        add = mk(5'd8, 5'd9, 5'd10, 6'b100000, 3'b010, CtrlR, 32'h0);
        cycle(lw, 0, 0, 0);
        cycle(add, 0, 0, 0);
        cycle(add, 0, 0, 0);

        // Load into $0 never stalls
        lw.rt = 5'd0;
        add.rs = 5'd0;
        cycle(lw, 0, 0, 0);
        cycle(add, 0, 0, 0);

        // Flush together with load-use: bubble, PC advances, counter unchanged
        lw.rt = 5'd8;
        add.rs = 5'd8;
        cycle(lw, 0, 0, 0);
        cycle(add, 1, 0, 0);

        // Hold freezes ori in EX for three cycles
        ori = mk(5'd3, 5'd4, 5'd0, 6'd0, 3'b100, CtrlOri, 32'h0000_00ff);
        cycle(ori, 0, 0, 0);
        for (int i = 0; i < 3; i++) cycle(rand_in(), 0, 1, 0);
        cycle(add, 0, 0, 0);

        // Four load-use pairs: counter walks up and saturates
        for (int i = 0; i < 4; i++) begin
            cycle(lw, 0, 0, 0);
            cycle(add, 0, 0, 0);
            cycle(add, 0, 0, 0);
        end

        // Reset asserted while a load-use stall is in progress
        cycle(lw, 0, 0, 0);
        cycle(add, 0, 0, 1);
        cycle(add, 0, 0, 0);

        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 2) == 0) cycle(mk(pick_reg(), pick_reg(), 5'($urandom),
                6'($urandom), 3'b000, CtrlLw | 7'($urandom & 32'h49), $urandom), 0, 0, 0);
            else cycle(rand_in(), ($urandom_range(0, 9) == 0), ($urandom_range(0, 9) == 0),
                       ($urandom_range(0, 99) == 0));
        end

        repeat (3) @(negedge clk);
        check("queues_drained", 192'(comb_q.size() + st_q.size()), 192'(0));
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/id_ex_stage.md
ID_EX_STAGE -- requirements
Module: id_ex_stage

Interface
REQ-001 Parameter DW, default 32, datapath width of operand, immediate and PC fields.
REQ-002 Parameter CW, default 16, width of the stall-event counter.
REQ-003 clk  in  1  single clock; all state updates on its rising edge.
REQ-004 rst_n  in  1  asynchronous active-low reset.
REQ-005 id_valid  in  1  ID stage holds a real instruction.
REQ-006 id_pc4, id_rs_data, id_rt_data, id_imm  in  DW each  PC+4, register-file reads, sign-extended immediate.
REQ-007 id_rs, id_rt, id_rd  in  5 each  register specifiers.
REQ-008 id_funct  in  6  R-type funct field; id_alu_op  in  3  main-control ALUOp.
REQ-009 id_ctrl  in  7  {reg_dst, alu_src, mem_read, mem_write, mem_to_reg, reg_write, branch}, MSB first.
REQ-010 flush  in  1  branch taken; squash the instruction entering EX.
REQ-011 hold  in  1  downstream memory stall; freeze the whole front end.
REQ-012 ex_valid, ex_pc4, ex_rs_data, ex_rt_data, ex_imm, ex_rs, ex_rt, ex_rd, ex_funct, ex_alu_op, ex_ctrl  out  same widths  registered ID/EX fields; ex_funct and ex_alu_op drive the ALU control stage.
REQ-013 pc_write, if_id_write  out  1 each  enables for PC and IF/ID register.
REQ-014 stall_cnt  out  CW  saturating count of load-use bubbles inserted.

Function
REQ-015 Load-use hazard lu = ex_valid & ex_ctrl.mem_read & id_valid & ex_rt!=0 & (ex_rt==id_rs | ex_rt==id_rt), combinational.
REQ-016 Update priority per edge: hold > flush > lu > normal load.
REQ-017 hold=1: all ex_* retain value; pc_write=0, if_id_write=0; stall_cnt unchanged.
REQ-018 flush=1, hold=0: load bubble; pc_write=1, if_id_write=1 (fetch redirect owns the PC mux); stall_cnt unchanged.
REQ-019 lu=1, hold=0, flush=0: load bubble; pc_write=0, if_id_write=0; stall_cnt increments.
REQ-020 Otherwise: all id_* captured into ex_* with 1-cycle latency; pc_write=1, if_id_write=1.
REQ-021 Bubble = ex_valid=0, ex_ctrl=0, ex_alu_op=3'b000, ex_funct=0, all other ex_* fields 0.
REQ-022 pc_write and if_id_write are combinational from current hold/flush/lu.
REQ-023 stall_cnt saturates at 2^CW-1; no wrap.
REQ-024 A bubble never raises lu next cycle (ex_valid=0 masks it); a load followed by a dependent instruction stalls exactly one cycle.
REQ-025 Register $0 as ex_rt never causes a stall.

Reset
REQ-026 rst_n low asynchronously forces ex_* to the bubble value and stall_cnt to 0.
REQ-027 Deassertion is synchronised externally; first edge after release performs a normal REQ-016 update.
REQ-028 Reset mid-stall discards the stall; no pending state survives.

Structure
REQ-029 Shared package mips_pkg holds ALUOp encodings (000 lw/sw, 001 branch, 010 R-type, 011 andi, 100 ori, 111 slti), funct codes (add 100000, sub 100010, and 100100, or 100101, slt 101010), id_ctrl bit indices, bubble constant.
REQ-030 Sub-module hazard_unit computes lu, pc_write and if_id_write; id_ex_stage holds the register and counter.

Verification
REQ-031 lw $t0 (rt=8, mem_read) in EX, add with id_rs=8 valid -> pc_write=0, if_id_write=0, next ex_valid=0, stall_cnt 0->1; following cycle add enters EX with ex_funct=100000, ex_alu_op=010.
REQ-032 Same as REQ-031 with ex_rt=0 -> no stall, add captured next edge.
REQ-033 flush=1 with lu=1 simultaneously -> bubble, pc_write=1, stall_cnt unchanged.
REQ-034 hold=1 for 3 cycles with ori (alu_op=100, imm=0x00FF) in EX -> ex_* stable, pc_write=0; ori still in EX after release.
REQ-035 CW=2, four back-to-back load-use pairs -> stall_cnt reads 1,2,3,3.
REQ-036 rst_n low during lu stall -> ex_valid=0, ex_ctrl=0, stall_cnt=0 immediately, without a clock edge.
